// File: rtl/rps_game_controller_if.sv
// Player-side signal bundle for rps_game_controller: button/switch inputs plus display-phase outputs.
// play is a level-sensitive button (no valid/ready); every output is registered in the controller.
interface rps_game_controller_if;
  logic       play;
  logic [2:0] choice;
  logic [1:0] state;
  logic [7:0] fpgachoice;
  logic [1:0] score;
  logic [7:0] ctn;
  logic [3:0] wins;
  logic [3:0] losses;

  modport master (output play, choice,
                  input  state, fpgachoice, score, ctn, wins, losses);
  modport slave  (input  play, choice,
                  output state, fpgachoice, score, ctn, wins, losses);
endinterface

// File: rtl/rps_game_controller.sv
// Rock-paper-scissors(-lizard-spock) sequencer: IDLE -> REVEAL -> RESULT on a prescaled tick.
// Define RPS_LIZARD_SPOCK_EN for the five-move game; undefined builds the classic three-move game.
module rps_game_controller #(
    parameter int TICK_DIV     = 500000,
    parameter int SHOW_TICKS   = 100,
    parameter int RESULT_TICKS = 110
) (
    input logic Clock,
    input logic Reset,
    rps_game_controller_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
`ifdef RPS_LIZARD_SPOCK_EN
    localparam logic [7:0] MAXPICK   = 8'd98;
    localparam logic [2:0] MAXCHOICE = 3'd4;
`else
    localparam logic [7:0] MAXPICK   = 8'd58;
    localparam logic [2:0] MAXCHOICE = 3'd2;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, REVEAL = 2'd1, RESULT = 2'd2} state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] presc_q, presc_n;
    logic [7:0]    ctn_q, ctn_n;
    logic [7:0]    pick_q, pick_n;
    logic [2:0]    choice_q, choice_n;
    logic [1:0]    score_q, score_n;
    logic [3:0]    wins_q, wins_n;
    logic [3:0]    losses_q, losses_n;
    logic          play_d;
    logic          tick, rise, choice_ok;
    logic [1:0]    round_result;

    function automatic logic [2:0] decode(input logic [7:0] p);
        if (p <= 8'd18)      decode = 3'd0;
        else if (p <= 8'd38) decode = 3'd1;
        else if (p <= 8'd58) decode = 3'd2;
        else if (p <= 8'd78) decode = 3'd3;
        else                 decode = 3'd4;
    endfunction

    // 0 tie, 1 player (p) beats fpga (f), 2 player loses
    function automatic logic [1:0] outcome(input logic [2:0] p, input logic [2:0] f);
        logic win;
        win = 1'b0;
        case (p)
            3'd0: win = (f == 3'd2) || (f == 3'd3);
            3'd1: win = (f == 3'd0) || (f == 3'd4);
            3'd2: win = (f == 3'd1) || (f == 3'd3);
`ifdef RPS_LIZARD_SPOCK_EN
            3'd3: win = (f == 3'd1) || (f == 3'd4);
            3'd4: win = (f == 3'd0) || (f == 3'd2);
`endif
            default: win = 1'b0;
        endcase
        if (p == f)   outcome = 2'd0;
        else if (win) outcome = 2'd1;
        else          outcome = 2'd2;
    endfunction

    assign tick         = (presc_q == PW'(TICK_DIV - 1));
    assign rise         = bus.play & ~play_d;
    assign choice_ok    = (bus.choice <= MAXCHOICE);
    assign round_result = outcome(choice_q, decode(pick_q));

    always_comb begin
        state_n  = state_q;
        presc_n  = presc_q;
        ctn_n    = ctn_q;
        pick_n   = pick_q;
        choice_n = choice_q;
        score_n  = score_q;
        wins_n   = wins_q;
        losses_n = losses_q;
        case (state_q)
            IDLE: begin
                ctn_n   = 8'd0;
                presc_n = '0;
                if (rise && choice_ok) begin
                    // pick_q is left untouched so the value seen this cycle is the captured one
                    choice_n = bus.choice;
                    state_n  = REVEAL;
                end else begin
                    pick_n = (pick_q == MAXPICK) ? 8'd0 : pick_q + 8'd1;
                end
            end
            REVEAL: begin
                if (!tick) begin
                    presc_n = presc_q + PW'(1);
                end else if (ctn_q == 8'(SHOW_TICKS - 1)) begin
                    score_n = round_result;
                    if (round_result == 2'd1 && wins_q != 4'd9)   wins_n   = wins_q + 4'd1;
                    if (round_result == 2'd2 && losses_q != 4'd9) losses_n = losses_q + 4'd1;
                    state_n = RESULT;
                    ctn_n   = 8'd0;
                    presc_n = '0;
                end else begin
                    ctn_n   = ctn_q + 8'd1;
                    presc_n = '0;
                end
            end
            RESULT: begin
                if (!tick) begin
                    presc_n = presc_q + PW'(1);
                end else if (ctn_q == 8'(RESULT_TICKS - 1)) begin
                    state_n = IDLE;
                    ctn_n   = 8'd0;
                    presc_n = '0;
                end else begin
                    ctn_n   = ctn_q + 8'd1;
                    presc_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            ctn_q    <= 8'd0;
            pick_q   <= 8'd0;
            choice_q <= 3'd0;
            score_q  <= 2'd0;
            wins_q   <= 4'd0;
            losses_q <= 4'd0;
            play_d   <= 1'b0;
        end else begin
            state_q  <= state_n;
            presc_q  <= presc_n;
            ctn_q    <= ctn_n;
            pick_q   <= pick_n;
            choice_q <= choice_n;
            score_q  <= score_n;
            wins_q   <= wins_n;
            losses_q <= losses_n;
            play_d   <= bus.play;
        end
    end

    assign bus.state      = state_q;
    assign bus.fpgachoice = pick_q;
    assign bus.score      = score_q;
    assign bus.ctn        = ctn_q;
    assign bus.wins       = wins_q;
    assign bus.losses     = losses_q;
endmodule

// File: tb/tb_rps_game_controller.sv
// Directed bench for rps_game_controller with TICK_DIV=2, SHOW_TICKS=4, RESULT_TICKS=5.
// Covers both builds; the vector table follows RPS_LIZARD_SPOCK_EN.
module tb_rps_game_controller;
  localparam int TICK_DIV     = 2;
  localparam int SHOW_TICKS   = 4;
  localparam int RESULT_TICKS = 5;
`ifdef RPS_LIZARD_SPOCK_EN
  localparam int MAXPICK = 98;
`else
  localparam int MAXPICK = 58;
`endif

  logic clk;
  logic rst;
  int   ncmp;
  int   nerr;
  int   ew;
  int   el;

  rps_game_controller_if bus ();

  rps_game_controller #(
    .TICK_DIV    (TICK_DIV),
    .SHOW_TICKS  (SHOW_TICKS),
    .RESULT_TICKS(RESULT_TICKS)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [2:0] ch;
    int         pick;
    int         score;
    int         wins;
    int         losses;
  } vec_t;
  vec_t vq[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(bus.state), 0);
    check({tag, "_fpgachoice"}, int'(bus.fpgachoice), 0);
    check({tag, "_score"}, int'(bus.score), 0);
    check({tag, "_ctn"}, int'(bus.ctn), 0);
    check({tag, "_wins"}, int'(bus.wins), 0);
    check({tag, "_losses"}, int'(bus.losses), 0);
  endtask

  // driver: poll the free-running pick until it shows v (bounded)
  task automatic wait_pick(input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(bus.fpgachoice) != v && n < 300);
    check("wait_pick", int'(bus.fpgachoice), v);
  endtask

  task automatic do_round(input logic [2:0] ch, input int pick, input int e_score,
                          input int e_w, input int e_l, input bit hold);
    bus.choice = ch;
    wait_pick(pick);
    bus.play = 1'b1;
    @(negedge clk);
    check("start_state", int'(bus.state), 1);
    check("start_pick_held", int'(bus.fpgachoice), pick);
    check("start_ctn", int'(bus.ctn), 0);
    bus.choice = 3'd5;
    if (!hold) bus.play = 1'b0;
    repeat (SHOW_TICKS * TICK_DIV - 1) @(negedge clk);
    check("reveal_last_state", int'(bus.state), 1);
    check("reveal_last_ctn", int'(bus.ctn), SHOW_TICKS - 1);
    @(negedge clk);
    check("result_state", int'(bus.state), 2);
    check("result_score", int'(bus.score), e_score);
    check("result_wins", int'(bus.wins), e_w);
    check("result_losses", int'(bus.losses), e_l);
    check("result_ctn", int'(bus.ctn), 0);
    check("result_pick_held", int'(bus.fpgachoice), pick);
    repeat (RESULT_TICKS * TICK_DIV - 1) @(negedge clk);
    check("result_last_state", int'(bus.state), 2);
    @(negedge clk);
    check("idle_state", int'(bus.state), 0);
    check("idle_score_held", int'(bus.score), e_score);
    if (hold) begin
      repeat (6) @(negedge clk);
      check("hold_no_restart", int'(bus.state), 0);
      bus.play = 1'b0;
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst = 1'b1;
    bus.play = 1'b0;
    bus.choice = 3'd0;

`ifdef RPS_LIZARD_SPOCK_EN
    vq.push_back('{3'd2, 25, 1, 1, 0});
    vq.push_back('{3'd0, 85, 2, 1, 1});
    vq.push_back('{3'd3, 60, 0, 1, 1});
    vq.push_back('{3'd4,  5, 1, 2, 1});
    vq.push_back('{3'd1, 40, 2, 2, 2});
    vq.push_back('{3'd3, 79, 1, 3, 2});
    vq.push_back('{3'd0, 18, 0, 3, 2});
`else
    vq.push_back('{3'd2, 25, 1, 1, 0});
    vq.push_back('{3'd0, 30, 2, 1, 1});
    vq.push_back('{3'd1, 38, 0, 1, 1});
    vq.push_back('{3'd0, 58, 1, 2, 1});
    vq.push_back('{3'd1, 19, 0, 2, 1});
    vq.push_back('{3'd2,  0, 2, 2, 2});
`endif

    // reset state and free-running pick with wrap
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    for (int k = 1; k <= MAXPICK + 3; k++) begin
      @(negedge clk);
      check("pick_count", int'(bus.fpgachoice), k % (MAXPICK + 1));
    end

    // table-driven rounds
    ew = 0;
    el = 0;
    for (int i = 0; i < vq.size(); i++) begin
      do_round(vq[i].ch, vq[i].pick, vq[i].score, vq[i].wins, vq[i].losses, 1'b0);
      ew = vq[i].wins;
      el = vq[i].losses;
    end

    // play held through a whole round (rock vs rock tie)
    do_round(3'd0, 5, 0, ew, el, 1'b1);

    // win saturation
    for (int i = 0; i < 8; i++) begin
      ew = (ew < 9) ? ew + 1 : 9;
      do_round(3'd2, 25, 1, ew, el, 1'b0);
    end
    check("wins_saturated", int'(bus.wins), 9);

    // invalid choices are ignored
    bus.choice = 3'd6;
    wait_pick(10);
    bus.play = 1'b1;
    @(negedge clk);
    check("invalid6_state", int'(bus.state), 0);
    bus.play = 1'b0;
`ifndef RPS_LIZARD_SPOCK_EN
    bus.choice = 3'd4;
    wait_pick(12);
    bus.play = 1'b1;
    @(negedge clk);
    check("invalid4_state", int'(bus.state), 0);
    bus.play = 1'b0;
`endif

    // reset during REVEAL at ctn==2
    bus.choice = 3'd2;
    wait_pick(25);
    bus.play = 1'b1;
    @(negedge clk);
    bus.play = 1'b0;
    for (int n = 0; n < 20 && int'(bus.ctn) != 2; n++) @(negedge clk);
    check("midround_ctn", int'(bus.ctn), 2);
    check("midround_state", int'(bus.state), 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    do_round(3'd2, 25, 1, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
